descriptor_responder: RTL and testbench

AXI4 read-slave that stores 1024-bit job descriptors in on-chip RAM and returns them as INCR read bursts. It is the responder at the far end of the descriptor-fetch read channel: an initiator issues AR requests carrying a process ID in ARUSER, and this block answers with descriptor beats, RLAST and RRESP. Host-side logic preloads entries through a simple valid/ready load port. Descriptor content is not interpreted.

---
 rtl/descriptor_responder_if.sv | 53 +++++
 rtl/descriptor_responder.sv | 179 +++++++++++++++++
 tb/tb_descriptor_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/descriptor_responder_if.sv
// descriptor_responder_if
//   Bundles the descriptor load port and the AXI4 AR/R read channels of
//   descriptor_responder.
//   slave  modport : the responder (drives ld_ready_o, arready and the R channel)
//   master modport : the host/initiator side (drives loads, AR and rready)
//   Load port : ld_valid_i/ld_ready_o handshake, ld_index_i entry, ld_data_i payload
//   AR channel: arid, araddr, arlen, arsize, arburst, aruser, arvalid/arready
//   R channel : rid, rdata, rresp, rlast, ruser, rvalid/rready
interface descriptor_responder_if #(
   parameter int ID_WIDTH     = 1,
   parameter int ARUSER_WIDTH = 9,
   parameter int DATA_WIDTH   = 1024,
   parameter int ADDR_WIDTH   = 64,
   parameter int DEPTH_LOG2   = 6
) ();
   logic                    ld_valid_i;
   logic                    ld_ready_o;
   logic [DEPTH_LOG2-1:0]   ld_index_i;
   logic [DATA_WIDTH-1:0]   ld_data_i;

   logic [ID_WIDTH-1:0]     s_axi_arid;
   logic [ADDR_WIDTH-1:0]   s_axi_araddr;
   logic [7:0]              s_axi_arlen;
   logic [2:0]              s_axi_arsize;
   logic [1:0]              s_axi_arburst;
   logic [ARUSER_WIDTH-1:0] s_axi_aruser;
   logic                    s_axi_arvalid;
   logic                    s_axi_arready;

   logic [ID_WIDTH-1:0]     s_axi_rid;
   logic [DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]              s_axi_rresp;
   logic                    s_axi_rlast;
   logic [ARUSER_WIDTH-1:0] s_axi_ruser;
   logic                    s_axi_rvalid;
   logic                    s_axi_rready;

   modport slave (
      input  ld_valid_i, ld_index_i, ld_data_i,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
      input  s_axi_aruser, s_axi_arvalid, s_axi_rready,
      output ld_ready_o, s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid
   );

   modport master (
      output ld_valid_i, ld_index_i, ld_data_i,
      output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
      output s_axi_aruser, s_axi_arvalid, s_axi_rready,
      input  ld_ready_o, s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser, s_axi_rvalid
   );
endinterface

// File: rtl/descriptor_responder.sv
// descriptor_responder
//   AXI4 read slave serving 1024-bit job descriptors out of on-chip RAM as INCR
//   bursts (one descriptor per beat). Entries are preloaded through the load port.
//   clk       : single clock
//   rst       : synchronous, active-high reset
//   bus       : load port + AXI AR/R channels (slave modport)
//   busy_o    : high while a burst is being served (state not IDLE)
//   err_cnt_o : saturating count of SLVERR bursts
module descriptor_responder #(
   parameter int                    ID_WIDTH     = 1,
   parameter int                    ARUSER_WIDTH = 9,
   parameter int                    DATA_WIDTH   = 1024,
   parameter int                    ADDR_WIDTH   = 64,
   parameter int                    DEPTH_LOG2   = 6,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   descriptor_responder_if.slave  bus,
   output logic                   busy_o,
   output logic [15:0]            err_cnt_o
);
   localparam int IW = DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } beat_t;

   // descriptor storage, not reset
   logic [DATA_WIDTH-1:0] mem_q [(1<<IW)];

   state_t                  state_q, state_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ARUSER_WIDTH-1:0] user_q, user_d;
   logic                    err_q, err_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [8:0]              rem_q, rem_d;      // RAM reads still to issue
   beat_t [1:0]             buf_q, buf_d;      // 2-entry output skid buffer
   logic                    wr_ptr_q, wr_ptr_d;
   logic                    rd_ptr_q, rd_ptr_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [15:0]             err_cnt_q, err_cnt_d;

   logic                    arready, ld_ready, ar_hs, ld_hs, rvalid, pop, issue;
   beat_t                   push_beat;

   // AR decode
   logic [ADDR_WIDTH-1:0]   ar_off;
   logic [IW-1:0]           ar_idx;
   logic                    ar_hi_nz;
   logic [IW+8:0]           ar_end;
   logic                    ar_err;

   always_comb begin
      ar_off   = bus.s_axi_araddr - BASE_ADDR;
      ar_idx   = ar_off[IW+6:7];
      // any offset bits above the entry range put the start past the table
      ar_hi_nz = |(ar_off >> (IW+7));
      ar_end   = {9'd0, ar_idx} + {{(IW+1){1'b0}}, bus.s_axi_arlen};
      ar_err   = (bus.s_axi_araddr < BASE_ADDR) ||
                 (bus.s_axi_araddr[6:0] != 7'd0) ||
                 (bus.s_axi_arsize != 3'd7) ||
                 (bus.s_axi_arburst != 2'b01) ||
                 ar_hi_nz ||
                 (ar_end[IW+8:IW] != '0);
   end

   // loads win over AR in IDLE; both readies held low while rst is high
   assign ld_ready = (state_q == IDLE) && !rst;
   assign arready  = (state_q == IDLE) && !bus.ld_valid_i && !rst;
   assign ld_hs    = bus.ld_valid_i && ld_ready;
   assign ar_hs    = bus.s_axi_arvalid && arready;
   assign rvalid   = (cnt_q != 2'd0);
   assign pop      = rvalid && bus.s_axi_rready;

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      user_d    = user_q;
      err_d     = err_q;
      idx_d     = idx_q;
      rem_d     = rem_q;
      buf_d     = buf_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      err_cnt_d = err_cnt_q;

      // read lands straight in the skid buffer one cycle after issue; only
      // issue while a slot is free so a stalled R channel never loses a beat
      issue          = (state_q == BURST) && (cnt_q != 2'd2);
      push_beat.data = err_q ? '0 : mem_q[idx_q];
      push_beat.resp = err_q ? 2'b10 : 2'b00;
      push_beat.last = (rem_q == 9'd1);

      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               id_d    = bus.s_axi_arid;
               user_d  = bus.s_axi_aruser;
               err_d   = ar_err;
               idx_d   = ar_idx;
               rem_d   = {1'b0, bus.s_axi_arlen} + 9'd1;
               state_d = BURST;
               if (ar_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
         end
         BURST: begin
            if (issue) begin
               buf_d[wr_ptr_q] = push_beat;
               wr_ptr_d        = ~wr_ptr_q;
               idx_d           = idx_q + IW'(1);
               rem_d           = rem_q - 9'd1;
               if (rem_q == 9'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && buf_q[rd_ptr_q].last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (pop) rd_ptr_d = ~rd_ptr_q;

      case ({issue, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         id_q      <= '0;
         user_q    <= '0;
         err_q     <= 1'b0;
         idx_q     <= '0;
         rem_q     <= '0;
         buf_q     <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         err_cnt_q <= 16'd0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         user_q    <= user_d;
         err_q     <= err_d;
         idx_q     <= idx_d;
         rem_q     <= rem_d;
         buf_q     <= buf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // single-port RAM: writes only happen in IDLE, reads only in BURST
   always_ff @(posedge clk) begin
      if (ld_hs) mem_q[bus.ld_index_i] <= bus.ld_data_i;
   end

   assign bus.ld_ready_o    = ld_ready;
   assign bus.s_axi_arready = arready;
   assign bus.s_axi_rvalid  = rvalid;
   assign bus.s_axi_rid     = id_q;
   assign bus.s_axi_ruser   = user_q;
   assign bus.s_axi_rdata   = buf_q[rd_ptr_q].data;
   assign bus.s_axi_rresp   = buf_q[rd_ptr_q].resp;
   assign bus.s_axi_rlast   = buf_q[rd_ptr_q].last;
   assign busy_o            = (state_q != IDLE);
   assign err_cnt_o         = err_cnt_q;
endmodule

// File: tb/tb_descriptor_responder.sv
module tb_descriptor_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic [15:0] err_cnt;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ar_t = 0;
   int          last_hs = 0;
   int          ld_t = 0;
   logic [1023:0] exp_mem [64];

   descriptor_responder_if #(.ID_WIDTH(1), .ARUSER_WIDTH(9), .DATA_WIDTH(1024),
                             .ADDR_WIDTH(64), .DEPTH_LOG2(6)) bus ();

   descriptor_responder #(.ID_WIDTH(1), .ARUSER_WIDTH(9), .DATA_WIDTH(1024),
                          .ADDR_WIDTH(64), .DEPTH_LOG2(6), .BASE_ADDR(64'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy_o    (busy),
      .err_cnt_o (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1023:0] pat(input int i);
      logic [1023:0] p;
      logic [31:0]   w;
      w = 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
      for (int j = 0; j < 32; j++) p[j*32 +: 32] = w + 32'(j);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      logic [127:0] ol, el;
      ol = obs[127:0];
      el = exp[127:0];
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got low128 %h expected low128 %h", tag, ol, el);
      end
   endtask

   task automatic load(input int idx, input logic [1023:0] d);
      @(negedge clk);
      bus.ld_valid_i = 1'b1;
      bus.ld_index_i = 6'(idx);
      bus.ld_data_i  = d;
      exp_mem[idx]   = d;
   endtask

   // caller is at a negedge; returns at the negedge after the handshake
   task automatic send_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [8:0] user, input logic id);
      bit got = 1'b0;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = len;
      bus.s_axi_arsize  = size;
      bus.s_axi_arburst = burst;
      bus.s_axi_aruser  = user;
      bus.s_axi_arid    = id;
      bus.s_axi_arvalid = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (bus.s_axi_arready) begin
            got  = 1'b1;
            ar_t = cyc;
         end else @(negedge clk);
      end
      chk("ar_accept", 128'(got), 128'd1);
      @(negedge clk);
      bus.s_axi_arvalid = 1'b0;
   endtask

   task automatic collect(input int n, input int tot, input logic [11:0] rp, input int sidx,
                          input logic err, input logic [8:0] user, input logic id, input bit lat);
      int k = 0;
      int i = 0;
      bit stalled = 1'b0;
      logic [1023:0] sd, ed;
      logic [1:0] sr;
      logic sl;
      while (k < n && i < 200) begin
         @(negedge clk);
         bus.s_axi_rready = rp[i % 12];
         i++;
         if (stalled) begin
            chk("stall_rvalid", 128'(bus.s_axi_rvalid), 128'd1);
            chk_data("stall_rdata", bus.s_axi_rdata, sd);
            chk("stall_rresp", 128'(bus.s_axi_rresp), 128'(sr));
            chk("stall_rlast", 128'(bus.s_axi_rlast), 128'(sl));
            stalled = 1'b0;
         end
         if (bus.s_axi_rvalid) begin
            if (bus.s_axi_rready) begin
               ed = '0;
               if (!err) ed = exp_mem[sidx + k];
               chk_data($sformatf("beat%0d_rdata", k), bus.s_axi_rdata, ed);
               chk($sformatf("beat%0d_rresp", k), 128'(bus.s_axi_rresp), err ? 128'd2 : 128'd0);
               chk($sformatf("beat%0d_rlast", k), 128'(bus.s_axi_rlast), 128'(k == tot - 1));
               chk($sformatf("beat%0d_ruser", k), 128'(bus.s_axi_ruser), 128'(user));
               chk($sformatf("beat%0d_rid", k), 128'(bus.s_axi_rid), 128'(id));
               if (lat) chk($sformatf("beat%0d_cycle", k), 128'(cyc), 128'(ar_t + 2 + k));
               last_hs = cyc;
               k++;
            end else begin
               stalled = 1'b1;
               sd = bus.s_axi_rdata;
               sr = bus.s_axi_rresp;
               sl = bus.s_axi_rlast;
            end
         end
      end
      chk("beats_done", 128'(k), 128'(n));
   endtask

   initial begin
      bus.ld_valid_i    = 1'b0;
      bus.ld_index_i    = '0;
      bus.ld_data_i     = '0;
      bus.s_axi_arid    = '0;
      bus.s_axi_araddr  = '0;
      bus.s_axi_arlen   = '0;
      bus.s_axi_arsize  = 3'd7;
      bus.s_axi_arburst = 2'b01;
      bus.s_axi_aruser  = '0;
      bus.s_axi_arvalid = 1'b1;   // ready must still be low during reset
      bus.s_axi_rready  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_rvalid", 128'(bus.s_axi_rvalid), 128'd0);
      chk("rst_rlast", 128'(bus.s_axi_rlast), 128'd0);
      chk("rst_rresp", 128'(bus.s_axi_rresp), 128'd0);
      chk("rst_rid", 128'(bus.s_axi_rid), 128'd0);
      chk("rst_ruser", 128'(bus.s_axi_ruser), 128'd0);
      chk_data("rst_rdata", bus.s_axi_rdata, '0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_err_cnt", 128'(err_cnt), 128'd0);
      chk("rst_arready", 128'(bus.s_axi_arready), 128'd0);
      chk("rst_ld_ready", 128'(bus.ld_ready_o), 128'd0);
      rst = 1'b0;
      bus.s_axi_arvalid = 1'b0;
      #1;
      chk("idle_arready", 128'(bus.s_axi_arready), 128'd1);
      chk("idle_ld_ready", 128'(bus.ld_ready_o), 128'd1);

      // preload
      for (int i = 0; i < 12; i++) load(i, pat(i));
      load(62, pat(62));
      load(63, pat(63));
      @(negedge clk);
      bus.ld_valid_i = 1'b0;

      // basic 4-beat burst, full throughput, latency T+2
      send_ar(64'h0, 8'd3, 3'd7, 2'b01, 9'h05, 1'b0);
      collect(4, 4, 12'hFFF, 0, 1'b0, 9'h05, 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_no_extra_beat", 128'(bus.s_axi_rvalid), 128'd0);
      chk("t1_busy_done", 128'(busy), 128'd0);

      // same burst with rready toggling
      send_ar(64'h0, 8'd3, 3'd7, 2'b01, 9'h05, 1'b1);
      collect(4, 4, 12'b101001101001, 0, 1'b0, 9'h05, 1'b1, 1'b0);
      @(negedge clk);
      chk("t2_no_extra_beat", 128'(bus.s_axi_rvalid), 128'd0);

      // misaligned address -> SLVERR
      send_ar(64'h40, 8'd1, 3'd7, 2'b01, 9'h1A, 1'b0);
      collect(2, 2, 12'hFFF, 0, 1'b1, 9'h1A, 1'b0, 1'b1);
      @(negedge clk);
      chk("t3_err_cnt", 128'(err_cnt), 128'd1);

      // overrun: index 62 + len 3 -> SLVERR
      send_ar(64'h1F00, 8'd3, 3'd7, 2'b01, 9'h07, 1'b0);
      collect(4, 4, 12'hFFF, 62, 1'b1, 9'h07, 1'b0, 1'b1);
      @(negedge clk);
      chk("t4_err_cnt", 128'(err_cnt), 128'd2);
      chk("t4_busy_bubble", 128'(busy), 128'd0);
      // next AR handshakes the cycle right after RLAST
      send_ar(64'h1F00, 8'd1, 3'd7, 2'b01, 9'h07, 1'b1);
      chk("t4_bubble_cycle", 128'(ar_t), 128'(last_hs + 1));
      collect(2, 2, 12'hFFF, 62, 1'b0, 9'h07, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_err_cnt_ok", 128'(err_cnt), 128'd2);

      // last entry, single beat, boundary is OK
      send_ar(64'h1F80, 8'd0, 3'd7, 2'b01, 9'h1FF, 1'b0);
      collect(1, 1, 12'hFFF, 63, 1'b0, 9'h1FF, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_err_cnt", 128'(err_cnt), 128'd2);

      // bad ARSIZE -> SLVERR
      send_ar(64'h0, 8'd0, 3'd6, 2'b01, 9'h02, 1'b0);
      collect(1, 1, 12'hFFF, 0, 1'b1, 9'h02, 1'b0, 1'b1);
      @(negedge clk);
      chk("t6_err_cnt", 128'(err_cnt), 128'd3);

      // load and AR in the same cycle: load wins, AR next cycle sees new data
      @(negedge clk);
      bus.ld_valid_i    = 1'b1;
      bus.ld_index_i    = 6'd2;
      bus.ld_data_i     = pat(100);
      exp_mem[2]        = pat(100);
      bus.s_axi_araddr  = 64'h100;
      bus.s_axi_arlen   = 8'd0;
      bus.s_axi_arsize  = 3'd7;
      bus.s_axi_arburst = 2'b01;
      bus.s_axi_arvalid = 1'b1;
      ld_t = cyc;
      #1;
      chk("t7_arready_blocked", 128'(bus.s_axi_arready), 128'd0);
      chk("t7_ld_ready", 128'(bus.ld_ready_o), 128'd1);
      @(negedge clk);
      bus.ld_valid_i = 1'b0;
      send_ar(64'h100, 8'd0, 3'd7, 2'b01, 9'h0F, 1'b0);
      chk("t7_ar_cycle", 128'(ar_t), 128'(ld_t + 1));
      collect(1, 1, 12'hFFF, 2, 1'b0, 9'h0F, 1'b0, 1'b1);

      // reset in the middle of an 8-beat burst
      @(negedge clk);
      send_ar(64'h200, 8'd7, 3'd7, 2'b01, 9'h33, 1'b1);
      collect(2, 8, 12'hFFF, 4, 1'b0, 9'h33, 1'b1, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      bus.s_axi_rready = 1'b0;
      @(negedge clk);
      chk("t8_rvalid_drop", 128'(bus.s_axi_rvalid), 128'd0);
      chk("t8_rlast", 128'(bus.s_axi_rlast), 128'd0);
      chk("t8_busy", 128'(busy), 128'd0);
      chk("t8_arready_rst", 128'(bus.s_axi_arready), 128'd0);
      chk("t8_ld_ready_rst", 128'(bus.ld_ready_o), 128'd0);
      rst = 1'b0;
      #1;
      chk("t8_arready_after", 128'(bus.s_axi_arready), 128'd1);
      chk("t8_err_cnt_clr", 128'(err_cnt), 128'd0);
      @(negedge clk);
      send_ar(64'h200, 8'd7, 3'd7, 2'b01, 9'h33, 1'b1);
      collect(8, 8, 12'hFFF, 4, 1'b0, 9'h33, 1'b1, 1'b1);
      @(negedge clk);
      chk("t8_no_extra_beat", 128'(bus.s_axi_rvalid), 128'd0);
      chk("t8_busy_done", 128'(busy), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
